// File: rtl/row_clear_scanner_pkg.sv
// Shared definitions for the row clear scanner.
// Holds the default board geometry, the guard length and the scanner
// FSM state encoding.
package row_clear_scanner_pkg;

  localparam int unsigned BLOCKS_WIDE  = 10;  // board columns
  localparam int unsigned BLOCKS_HIGH  = 20;  // board rows
  localparam int unsigned BITS_Y_POS   = 5;   // row-index width
  localparam int unsigned GUARD_CYCLES = 2;   // idle cycles after an ack

  typedef enum logic [1:0] {
    StScan  = 2'd0,
    StHold  = 2'd1,
    StGuard = 2'd2
  } state_e;

endpackage

// File: rtl/row_clear_scanner_full_check.sv
// Combinational full-row test.
// Ports:
//   row_i  - one board row slice
//   full_o - high when every cell of the row is occupied
module row_full_check #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] row_i,
  output logic             full_o
);

  assign full_o = &row_i;

endmodule

// File: rtl/row_clear_scanner.sv
// Row clear scanner: sweeps the board from the top row down looking for a
// fully occupied row, presents it to a consumer and waits for an ack, then
// idles for a guard period before sweeping again.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   fallen_pieces  - board occupancy, row r at [r*BLOCKS_WIDE +: BLOCKS_WIDE]
//   pause          - freezes scanning / holds off the rescan after a guard
//   flush          - synchronous restart, clears all counters
//   ack            - consumer accepted the presented row
//   row, valid     - presented full row index and its qualifier
//   sweep_done     - one-cycle pulse after a sweep that found no full row
//   sweep_clears   - rows acked during the sweep that just ended
//   total_lines    - lifetime acked rows, saturating
module row_clear_scanner #(
  parameter int unsigned BLOCKS_WIDE  = row_clear_scanner_pkg::BLOCKS_WIDE,
  parameter int unsigned BLOCKS_HIGH  = row_clear_scanner_pkg::BLOCKS_HIGH,
  parameter int unsigned BITS_Y_POS   = row_clear_scanner_pkg::BITS_Y_POS,
  parameter int unsigned GUARD_CYCLES = row_clear_scanner_pkg::GUARD_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_pieces,
  input  logic                              pause,
  input  logic                              flush,
  input  logic                              ack,
  output logic [BITS_Y_POS-1:0]             row,
  output logic                              valid,
  output logic                              sweep_done,
  output logic [BITS_Y_POS-1:0]             sweep_clears,
  output logic [15:0]                       total_lines
);

  import row_clear_scanner_pkg::*;

  localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [BITS_Y_POS-1:0] TopRow = BITS_Y_POS'(BLOCKS_HIGH - 1);
  localparam logic [BITS_Y_POS-1:0] RunMax = BITS_Y_POS'(BLOCKS_HIGH);

  state_e                  state_q, state_d;
  logic [BITS_Y_POS-1:0]   scan_idx_q, scan_idx_d;
  logic [BITS_Y_POS-1:0]   row_q, row_d;
  logic                    valid_q, valid_d;
  logic                    sweep_done_q, sweep_done_d;
  logic [BITS_Y_POS-1:0]   sweep_clears_q, sweep_clears_d;
  logic [BITS_Y_POS-1:0]   run_cnt_q, run_cnt_d;
  logic [15:0]             total_lines_q, total_lines_d;
  logic [GuardW-1:0]       guard_cnt_q, guard_cnt_d;

  logic [BLOCKS_WIDE-1:0]  row_slice;
  logic                    row_full;
  logic                    guard_done;

  // Row mux written with constant slices so the select stays index-width clean.
  always_comb begin
    row_slice = '0;
    for (int r = 0; r < int'(BLOCKS_HIGH); r++) begin
      if (scan_idx_q == BITS_Y_POS'(r)) begin
        row_slice = fallen_pieces[r*BLOCKS_WIDE +: BLOCKS_WIDE];
      end
    end
  end

  row_full_check #(
    .WIDTH (BLOCKS_WIDE)
  ) u_row_full_check (
    .row_i  (row_slice),
    .full_o (row_full)
  );

  // Guard counter runs 0..GUARD_CYCLES-1, so GUARD lasts at least GUARD_CYCLES cycles.
  assign guard_done = (32'(guard_cnt_q) + 32'd1) >= GUARD_CYCLES;

  always_comb begin
    state_d        = state_q;
    scan_idx_d     = scan_idx_q;
    row_d          = row_q;
    valid_d        = valid_q;
    sweep_done_d   = 1'b0;
    sweep_clears_d = sweep_clears_q;
    run_cnt_d      = run_cnt_q;
    total_lines_d  = total_lines_q;
    guard_cnt_d    = guard_cnt_q;

    if (flush) begin
      state_d        = StScan;
      scan_idx_d     = TopRow;
      valid_d        = 1'b0;
      sweep_clears_d = '0;
      run_cnt_d      = '0;
      total_lines_d  = '0;
      guard_cnt_d    = '0;
    end else begin
      unique case (state_q)
        StScan: begin
          if (!pause) begin
            if (row_full) begin
              row_d   = scan_idx_q;
              valid_d = 1'b1;
              state_d = StHold;
            end else if (scan_idx_q == '0) begin
              sweep_done_d   = 1'b1;
              sweep_clears_d = run_cnt_q;
              run_cnt_d      = '0;
              scan_idx_d     = TopRow;
            end else begin
              scan_idx_d = scan_idx_q - BITS_Y_POS'(1);
            end
          end
        end
        StHold: begin
          if (ack) begin
            valid_d     = 1'b0;
            guard_cnt_d = '0;
            state_d     = StGuard;
            if (run_cnt_q != RunMax) begin
              run_cnt_d = run_cnt_q + BITS_Y_POS'(1);
            end
            if (total_lines_q != 16'hFFFF) begin
              total_lines_d = total_lines_q + 16'd1;
            end
          end
        end
        StGuard: begin
          if (!guard_done) begin
            guard_cnt_d = guard_cnt_q + GuardW'(1);
          end else if (!pause) begin
            scan_idx_d = TopRow;
            state_d    = StScan;
          end
        end
        default: begin
          state_d    = StScan;
          scan_idx_d = TopRow;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StScan;
      scan_idx_q     <= TopRow;
      row_q          <= '0;
      valid_q        <= 1'b0;
      sweep_done_q   <= 1'b0;
      sweep_clears_q <= '0;
      run_cnt_q      <= '0;
      total_lines_q  <= '0;
      guard_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      scan_idx_q     <= scan_idx_d;
      row_q          <= row_d;
      valid_q        <= valid_d;
      sweep_done_q   <= sweep_done_d;
      sweep_clears_q <= sweep_clears_d;
      run_cnt_q      <= run_cnt_d;
      total_lines_q  <= total_lines_d;
      guard_cnt_q    <= guard_cnt_d;
    end
  end

  assign row          = row_q;
  assign valid        = valid_q;
  assign sweep_done   = sweep_done_q;
  assign sweep_clears = sweep_clears_q;
  assign total_lines  = total_lines_q;

endmodule

// File: doc/row_clear_scanner.md
ROW_CLEAR_SCANNER -- requirements
Module: row_clear_scanner

Interface
REQ-001 Parameter BLOCKS_WIDE, default 10, board columns.
REQ-002 Parameter BLOCKS_HIGH, default 20, board rows.
REQ-003 Parameter BITS_Y_POS, default 5, row-index width.
REQ-004 Parameter GUARD_CYCLES, default 2, minimum idle cycles after an ack before scanning resumes.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset; one clock, asynchronous, active-low.
REQ-007 fallen_pieces  in  BLOCKS_WIDE*BLOCKS_HIGH  board occupancy; row r occupies bits [r*BLOCKS_WIDE +: BLOCKS_WIDE].
REQ-008 pause  in  1  freezes the scan when high; the consumer also holds it high while it shifts rows.
REQ-009 flush  in  1  synchronous abort for a new game; restarts the scan and clears counters.
REQ-010 ack  in  1  consumer accepted the presented row.
REQ-011 row  out  BITS_Y_POS  index of the full row presented.
REQ-012 valid  out  1  row is valid; stays high until ack.
REQ-013 sweep_done  out  1  one-cycle pulse when a full sweep finds no full row.
REQ-014 sweep_clears  out  BITS_Y_POS  rows acked since the previous sweep_done; updated with sweep_done.
REQ-015 total_lines  out  16  lifetime acked rows; saturates at 65535.

Function
REQ-016 The FSM SHALL have exactly three states: SCAN, HOLD and GUARD.
REQ-017 SCAN: each cycle with pause low, test row scan_idx; scan_idx starts at BLOCKS_HIGH-1 and decrements.
REQ-018 A row is full when all its BLOCKS_WIDE bits are 1; SCAN SHALL then register row=scan_idx and valid=1 on the next edge and go to HOLD.
REQ-019 In SCAN, if row 0 is tested and is not full, the block SHALL pulse sweep_done, load sweep_clears with the running count, zero the running count, and reload scan_idx to BLOCKS_HIGH-1.
REQ-020 Latency from a row becoming full (while it is the scanned row) to valid high SHALL be 1 cycle; a worst-case detection takes BLOCKS_HIGH+1 unpaused cycles.
REQ-021 HOLD: row and valid SHALL stay stable regardless of pause or fallen_pieces changes.
REQ-022 On ack in HOLD, the block SHALL:
- drop valid next cycle;
- increment the running count and total_lines (saturating);
- go to GUARD.
REQ-023 GUARD SHALL wait GUARD_CYCLES cycles, then wait for pause low, then enter SCAN with scan_idx=BLOCKS_HIGH-1.
REQ-024 ack outside HOLD SHALL be ignored.
REQ-025 flush in any state SHALL, on the next edge:
- set valid=0 and sweep_done=0;
- zero the running count, sweep_clears and total_lines;
- set scan_idx=BLOCKS_HIGH-1 and go to SCAN.
flush takes priority over ack in the same cycle; that ack is not counted.
REQ-026 pause high in SCAN SHALL hold scan_idx and suppress sweep_done.
REQ-027 The running count SHALL saturate at BLOCKS_HIGH.
REQ-028 sweep_done SHALL never be high in the same cycle as valid.

Reset
REQ-029 On rst_n low, asynchronously:
- state=SCAN, scan_idx=BLOCKS_HIGH-1;
- row=0, valid=0, sweep_done=0, sweep_clears=0, total_lines=0;
- running count=0, guard counter=0.
REQ-030 Reset deassertion SHALL be synchronised externally; the first scan occurs on the first edge after rst_n is high.

Structure
REQ-031 BLOCKS_WIDE, BLOCKS_HIGH, BITS_Y_POS and the state encodings SHALL live in the shared definitions header.
REQ-032 The full-row test SHALL be one combinational sub-module, row_full_check (input: one row slice; output: all-ones flag).
REQ-033 There SHALL be no other sub-modules.

Verification
REQ-034 Empty board, pause=0 -> sweep_done pulses every 20 cycles with sweep_clears=0; valid stays 0.
REQ-035 Row 19 full, row 5 full -> valid with row=19 first. Ack it and hold pause high for 3 cycles after ack, then low -> after the guard, valid with row=5. Ack it -> the next sweep_done carries sweep_clears=2; total_lines=2.
REQ-036 Row 7 full, valid high, pause high for 50 cycles, ack never sent -> row=7 and valid=1 hold throughout.
REQ-037 HOLD with row=3, flush and ack asserted together -> valid=0 next cycle; total_lines=0; scan restarts at 19.
REQ-038 Assert rst_n low mid-GUARD, asynchronous to clk -> outputs reach reset values before the next edge; scanning resumes from 19.
REQ-039 total_lines preloaded at 65535 via 65535 acks, then one more ack -> total_lines stays 65535.
